// File: rtl/dmux16_router.sv
// dmux16_router: steers a valid/ready word stream into two one-entry channel holding registers (a/b).
// Latency 1 cycle input-to-output; a full, stalled channel only blocks words aimed at it (in_ready low).
// Optional per-channel delivery counters are built when DMUX_ROUTER_CNT_EN is defined.
module dmux16_router #(
    parameter int WIDTH = 16
`ifdef DMUX_ROUTER_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             alt_mode,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready
`ifdef DMUX_ROUTER_CNT_EN
    ,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
`endif
);

    logic [WIDTH-1:0] a_data_q, a_data_d;
    logic [WIDTH-1:0] b_data_q, b_data_d;
    logic             a_valid_q, a_valid_d;
    logic             b_valid_q, b_valid_d;
    logic             ptr_q, ptr_d;

    logic tgt;
    logic a_take, b_take;
    logic acc, acc_a, acc_b;

    // in_sel is never looked at in alternation mode, so an X there cannot leak into routing
    assign tgt    = alt_mode ? ptr_q : in_sel;
    assign a_take = a_valid_q && a_ready;
    assign b_take = b_valid_q && b_ready;

    assign in_ready = rst_n && !clear &&
                      (tgt ? (!b_valid_q || b_ready) : (!a_valid_q || a_ready));

    assign acc   = in_valid && in_ready;
    assign acc_a = acc && !tgt;
    assign acc_b = acc && tgt;

    always_comb begin
        a_valid_d = a_valid_q;
        b_valid_d = b_valid_q;
        a_data_d  = a_data_q;
        b_data_d  = b_data_q;
        ptr_d     = ptr_q;

        if (a_take) a_valid_d = 1'b0;
        if (b_take) b_valid_d = 1'b0;
        if (acc_a) begin
            a_valid_d = 1'b1;
            a_data_d  = in_data;
        end
        if (acc_b) begin
            b_valid_d = 1'b1;
            b_data_d  = in_data;
        end
        if (acc && alt_mode) ptr_d = ~ptr_q;

        // Flush dominates; accept is already blocked because in_ready is low
        if (clear) begin
            a_valid_d = 1'b0;
            b_valid_d = 1'b0;
            ptr_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            a_data_q  <= '0;
            b_data_q  <= '0;
            ptr_q     <= 1'b0;
        end else begin
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
            a_data_q  <= a_data_d;
            b_data_q  <= b_data_d;
            ptr_q     <= ptr_d;
        end
    end

    assign a_data  = a_data_q;
    assign a_valid = a_valid_q;
    assign b_data  = b_data_q;
    assign b_valid = b_valid_q;

`ifdef DMUX_ROUTER_CNT_EN
    logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
    logic [CNT_W-1:0] b_cnt_q, b_cnt_d;

    // Counters track completed deliveries and deliberately ignore clear
    always_comb begin
        a_cnt_d = a_take ? a_cnt_q + CNT_W'(1) : a_cnt_q;
        b_cnt_d = b_take ? b_cnt_q + CNT_W'(1) : b_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt_q <= '0;
            b_cnt_q <= '0;
        end else begin
            a_cnt_q <= a_cnt_d;
            b_cnt_q <= b_cnt_d;
        end
    end

    assign a_count = a_cnt_q;
    assign b_count = b_cnt_q;
`endif

endmodule

// File: tb/tb_dmux16_router.sv
// Directed bench for dmux16_router; counter checks are compiled in with DMUX_ROUTER_CNT_EN.
module tb_dmux16_router;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        alt_mode;
    logic [15:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_data;
    logic        a_valid;
    logic        a_ready;
    logic [15:0] b_data;
    logic        b_valid;
    logic        b_ready;
`ifdef DMUX_ROUTER_CNT_EN
    logic [3:0]  a_count;
    logic [3:0]  b_count;
`endif

    int tests = 0;
    int fails = 0;

    dmux16_router #(
        .WIDTH(16)
`ifdef DMUX_ROUTER_CNT_EN
        , .CNT_W(4)
`endif
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .alt_mode (alt_mode),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready)
`ifdef DMUX_ROUTER_CNT_EN
        , .a_count(a_count)
        , .b_count(b_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; alt_mode = 1'b0; in_data = 16'hFFFF;
        in_sel = 1'b0; in_valid = 1'b1; a_ready = 1'b1; b_ready = 1'b1;
        #2;
        tests++; if (a_valid !== 1'b0) begin fails++; $display("FAIL reset_a_valid: got %b exp 0", a_valid); end
        tests++; if (b_valid !== 1'b0) begin fails++; $display("FAIL reset_b_valid: got %b exp 0", b_valid); end
        tests++; if (a_data !== 16'h0000) begin fails++; $display("FAIL reset_a_data: got %h exp 0000", a_data); end
        tests++; if (b_data !== 16'h0000) begin fails++; $display("FAIL reset_b_data: got %h exp 0000", b_data); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
        tick();
        tick();
        tests++; if (a_valid !== 1'b0) begin fails++; $display("FAIL reset_hold_a_valid: got %b exp 0", a_valid); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_routing();
        alt_mode = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
        in_data = 16'h1234; in_sel = 1'b0; in_valid = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL route_rdy0: got %b exp 1", in_ready); end
        tick();
        tests++; if (a_valid !== 1'b1 || a_data !== 16'h1234) begin fails++; $display("FAIL route_a: got v=%b d=%h exp v=1 d=1234", a_valid, a_data); end
        tests++; if (b_valid !== 1'b0) begin fails++; $display("FAIL route_b_idle: got %b exp 0", b_valid); end
        in_data = 16'hABCD; in_sel = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL route_rdy1: got %b exp 1", in_ready); end
        tick();
        tests++; if (b_valid !== 1'b1 || b_data !== 16'hABCD) begin fails++; $display("FAIL route_b: got v=%b d=%h exp v=1 d=abcd", b_valid, b_data); end
        tests++; if (a_valid !== 1'b0) begin fails++; $display("FAIL route_a_drained: got %b exp 0", a_valid); end
        in_valid = 1'b0;
        tick();
        tests++; if (b_valid !== 1'b0) begin fails++; $display("FAIL route_b_drained: got %b exp 0", b_valid); end
        tests++; if (a_data !== 16'h1234) begin fails++; $display("FAIL route_a_retain: got %h exp 1234", a_data); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [6];
        logic        sels  [6];
        words = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606};
        sels  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        alt_mode = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = words[i]; in_sel = sels[i]; in_valid = 1'b1;
            #1;
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_rdy%0d: got %b exp 1", i, in_ready); end
            tick();
            if (sels[i] == 1'b0) begin
                tests++; if (a_valid !== 1'b1 || a_data !== words[i]) begin fails++; $display("FAIL b2b_a%0d: got v=%b d=%h exp v=1 d=%h", i, a_valid, a_data, words[i]); end
            end else begin
                tests++; if (b_valid !== 1'b1 || b_data !== words[i]) begin fails++; $display("FAIL b2b_b%0d: got v=%b d=%h exp v=1 d=%h", i, b_valid, b_data, words[i]); end
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_alternation();
        logic [15:0] w;
        alt_mode = 1'b1; a_ready = 1'b1; b_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            w = 16'(i);
            in_data = w; in_sel = (i % 2 == 1) ? 1'b1 : 1'b0; in_valid = 1'b1;
            tick();
            if (i % 2 == 1) begin
                tests++; if (a_valid !== 1'b1 || a_data !== w || b_valid !== 1'b0) begin fails++; $display("FAIL alt_a%0d: got av=%b ad=%h bv=%b exp av=1 ad=%h bv=0", i, a_valid, a_data, b_valid, w); end
            end else begin
                tests++; if (b_valid !== 1'b1 || b_data !== w || a_valid !== 1'b0) begin fails++; $display("FAIL alt_b%0d: got bv=%b bd=%h av=%b exp bv=1 bd=%h av=0", i, b_valid, b_data, a_valid, w); end
            end
        end
        // pointer back at a after an even number of words
        in_data = 16'h0005; in_sel = 1'b1;
        tick();
        tests++; if (a_valid !== 1'b1 || a_data !== 16'h0005) begin fails++; $display("FAIL alt_ptr_end: got av=%b ad=%h exp av=1 ad=0005", a_valid, a_data); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        alt_mode = 1'b0; a_ready = 1'b0; b_ready = 1'b1;
        in_data = 16'h1111; in_sel = 1'b0; in_valid = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_rdy_first: got %b exp 1", in_ready); end
        tick();
        tests++; if (a_valid !== 1'b1 || a_data !== 16'h1111) begin fails++; $display("FAIL bp_a_first: got v=%b d=%h exp v=1 d=1111", a_valid, a_data); end
        in_data = 16'h2222;
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_rdy_blocked: got %b exp 0", in_ready); end
        in_sel = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_b_open: got %b exp 1", in_ready); end
        in_sel = 1'b0;
        tick();
        tests++; if (a_data !== 16'h1111 || a_valid !== 1'b1) begin fails++; $display("FAIL bp_hold: got v=%b d=%h exp v=1 d=1111", a_valid, a_data); end
        tests++; if (b_valid !== 1'b0) begin fails++; $display("FAIL bp_b_untouched: got %b exp 0", b_valid); end
        a_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_rdy_release: got %b exp 1", in_ready); end
        tick();
        tests++; if (a_valid !== 1'b1 || a_data !== 16'h2222) begin fails++; $display("FAIL bp_refill: got v=%b d=%h exp v=1 d=2222", a_valid, a_data); end
        in_valid = 1'b0;
        tick();
        tests++; if (a_valid !== 1'b0) begin fails++; $display("FAIL bp_drained: got %b exp 0", a_valid); end
    endtask

    task automatic test_flush();
        // pointer is at b here (odd word count in alternation)
        alt_mode = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
        in_data = 16'hAAAA; in_sel = 1'b0; in_valid = 1'b1;
        tick();
        in_data = 16'hBBBB; in_sel = 1'b1;
        tick();
        tests++; if (a_valid !== 1'b1 || b_valid !== 1'b1) begin fails++; $display("FAIL flush_fill: got av=%b bv=%b exp 1 1", a_valid, b_valid); end
        alt_mode = 1'b1; a_ready = 1'b1; b_ready = 1'b1;
        clear = 1'b1; in_data = 16'h9999;
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_in_ready: got %b exp 0", in_ready); end
        tick();
        clear = 1'b0; in_valid = 1'b0;
        tests++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin fails++; $display("FAIL flush_valids: got av=%b bv=%b exp 0 0", a_valid, b_valid); end
        tests++; if (a_data !== 16'hAAAA || b_data !== 16'hBBBB) begin fails++; $display("FAIL flush_no_accept: got ad=%h bd=%h exp aaaa bbbb", a_data, b_data); end
        in_data = 16'h5555; in_sel = 1'b1; in_valid = 1'b1;
        tick();
        tests++; if (a_valid !== 1'b1 || a_data !== 16'h5555 || b_valid !== 1'b0) begin fails++; $display("FAIL flush_ptr: got av=%b ad=%h bv=%b exp av=1 ad=5555 bv=0", a_valid, a_data, b_valid); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        alt_mode = 1'b0; a_ready = 1'b0; b_ready = 1'b1;
        in_data = 16'h7777; in_sel = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tests++; if (a_valid !== 1'b1) begin fails++; $display("FAIL arst_pre: got %b exp 1", a_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (a_valid !== 1'b0 || a_data !== 16'h0000) begin fails++; $display("FAIL arst_immediate: got v=%b d=%h exp v=0 d=0000", a_valid, a_data); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL arst_in_ready: got %b exp 0", in_ready); end
        tick();
        rst_n = 1'b1; a_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin fails++; $display("FAIL arst_quiet%0d: got av=%b bv=%b exp 0 0", i, a_valid, b_valid); end
        end
    endtask

`ifdef DMUX_ROUTER_CNT_EN
    task automatic test_counters();
        tests++; if (a_count !== 4'd0 || b_count !== 4'd0) begin fails++; $display("FAIL cnt_reset: got a=%0d b=%0d exp 0 0", a_count, b_count); end
        alt_mode = 1'b0; a_ready = 1'b1; b_ready = 1'b1; in_sel = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = 16'h0C00 + 16'(i); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tests++; if (b_count !== 4'd1) begin fails++; $display("FAIL cnt_b_wrap: got %0d exp 1", b_count); end
        tests++; if (a_count !== 4'd0) begin fails++; $display("FAIL cnt_a_idle: got %0d exp 0", a_count); end
        b_ready = 1'b0;
        in_data = 16'h0DDD; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        tests++; if (b_count !== 4'd1 || b_valid !== 1'b0) begin fails++; $display("FAIL cnt_clear: got cnt=%0d bv=%b exp cnt=1 bv=0", b_count, b_valid); end
        b_ready = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_routing();
        test_back_to_back();
        test_alternation();
        test_backpressure();
        test_flush();
        test_async_reset();
`ifdef DMUX_ROUTER_CNT_EN
        test_counters();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmux16_router.md
Name: dmux16_router

Overview:
- Sequencing controller for the 16-bit 1-to-2 demultiplexer datapath: accepts a valid/ready word stream and steers each word to output channel a or b.
- Each output channel has a one-entry holding register with its own valid/ready handshake, so a stalled consumer does not corrupt the other channel.
- Routing is either by per-word destination bit (matching DMux select: 0 → a, 1 → b) or automatic alternation (ping-pong).
- Sits between a single 16-bit producer and two downstream consumers.

Parameters:
- WIDTH, 16, data word width; all data ports and holding registers use this width.
- CNT_W, 16, width of per-channel word counters (optional feature only).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush of both holding registers and the alternation pointer
- alt_mode  input  1  0: route by in_sel; 1: alternate a, b, a, ...
- in_data  input  WIDTH  input word
- in_sel  input  1  destination when alt_mode=0 (0 → a, 1 → b)
- in_valid  input  1  producer has a word
- in_ready  output  1  router accepts the word this cycle
- a_data  output  WIDTH  channel a word
- a_valid  output  1  channel a holds a word
- a_ready  input  1  channel a consumer takes the word
- b_data  output  WIDTH  channel b word
- b_valid  output  1  channel b holds a word
- b_ready  input  1  channel b consumer takes the word
- a_count  output  CNT_W  words delivered on a (DMUX_ROUTER_CNT_EN only)
- b_count  output  CNT_W  words delivered on b (DMUX_ROUTER_CNT_EN only)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - a_valid=0, b_valid=0, a_data=0, b_data=0.
  - Alternation pointer ptr=0 (targets a).
  - Counters=0.
  - in_ready=0 while rst_n=0.
- Target selection:
  - tgt = in_sel when alt_mode=0.
  - tgt = ptr when alt_mode=1.
- in_ready (combinational) = !clear && (target holding register empty || that register drains this cycle, i.e. x_valid && x_ready). Full-throughput pass-through: 1 word/cycle per channel when the consumer is always ready.
- Accept when in_valid && in_ready:
  - in_data is loaded into the target register on the next rising edge.
  - The target x_valid=1 from the next cycle. Latency is 1 cycle.
  - The non-target channel is unchanged.
- Output handshake:
  - A word transfers when x_valid && x_ready.
  - Without a refill the same cycle, x_valid falls next cycle.
  - While x_valid && !x_ready, x_data and x_valid hold stable.
  - x_data retains its last value after drain (not zeroed).
- Pointer:
  - In alt_mode=1, ptr toggles on every accepted word.
  - In alt_mode=0, ptr holds its value.
  - A change of alt_mode is sampled each cycle; no pipeline drain is required.
- Backpressure isolation: a full, stalled channel blocks only words targeting it. in_ready=0 for such a word; the producer holds it (head-of-line blocking is accepted).
- clear=1:
  - On the next edge a_valid=0, b_valid=0, ptr=0.
  - in_ready=0, so no word is accepted.
  - A drain of a and b in the same cycle is still reported to the consumers but is discarded by the flush.
  - Clear wins over any simultaneous accept.
- Reset mid-transfer: held words are lost; valid outputs drop immediately (asynchronous).
- X safety: in_sel is ignored when alt_mode=1; in_data is ignored when in_valid=0.

Optional Feature:
- Macro DMUX_ROUTER_CNT_EN.
- When defined:
  - a_count and b_count increment by 1 on each completed output transfer (x_valid && x_ready).
  - They wrap modulo 2^CNT_W.
  - They reset to 0 on rst_n and are not affected by clear.
- When undefined:
  - a_count and b_count ports are absent.
  - No counter logic is synthesized.
  - All other behaviour is identical.

Test Plan:
- Directed routing: alt_mode=0, a_ready=b_ready=1, send 0x1234 (sel=0) then 0xABCD (sel=1) → a_valid with a_data=0x1234 one cycle after accept; b_data=0xABCD the following cycle; in_ready stays 1.
- Alternation: alt_mode=1, four words 0x0001..0x0004 → a receives 0x0001, 0x0003; b receives 0x0002, 0x0004; ptr=0 at end.
- Backpressure isolation: a_ready=0, send 0x1111→a (accepted), then 0x2222→a (in_ready=0, held), then raise a_ready → 0x1111 out, 0x2222 accepted the same cycle, a_data=0x2222 next cycle, never a gap or duplicate.
- Flush: a_valid=b_valid=1 with both readys low, assert clear with in_valid=1 → in_ready=0, next cycle both valids 0, ptr=0, input word not accepted.
- Async reset mid-operation: a_valid=1, drop rst_n between edges → a_valid=0 immediately, no data emitted after release until a new accept.
- Counters (DMUX_ROUTER_CNT_EN, CNT_W=4): deliver 17 words to b → b_count=1 (wrap), a_count=0; clear leaves counts unchanged.
